// File: rtl/mac_sipo_rx.sv
// mac_sipo_rx: reassembles two-byte frames from the MAC serializer into
// 16-bit words and buffers them in a small FIFO drained by valid/ready.
// Frames are delimited by the serializer load strobe (ld): the low byte
// follows one cycle after ld and the high byte follows two cycles after ld.
module mac_sipo_rx #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     ld,
  input  logic [7:0]               q,
  output logic [15:0]              word,
  output logic                     word_valid,
  input  logic                     word_ready,
  output logic                     overflow,
  input  logic                     clr_err,
  output logic [CNT_W-1:0]         drop_cnt,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  typedef enum logic [1:0] {IDLE, LO, HI} state_t;

  state_t          state_q, state_d;
  logic [7:0]      lo_q, lo_d;
  logic [LW-1:0]   wptr_q, wptr_d;
  logic [LW-1:0]   rptr_q, rptr_d;
  logic [LW-1:0]   level_q, level_d;
  logic            valid_q, valid_d;
  logic            ovf_q, ovf_d;
  logic [CNT_W-1:0] drop_q, drop_d, drop_base;
  logic [15:0]     mem_q [DEPTH];

  logic            push, abort, pop, full, wr_en, ovf_evt;
  logic [15:0]     push_word;

  // Frame framing FSM: capture low byte, then push {high, low} on the high byte.
  always_comb begin
    // NOTE: every signal driven here gets a default first so no latch is inferred.
    state_d   = state_q;
    lo_d      = lo_q;
    push      = 1'b0;
    abort     = 1'b0;
    push_word = {q, lo_q};
    case (state_q)
      IDLE: begin
        if (ld) state_d = LO;
      end
      LO: begin
        lo_d = q;
        if (ld) begin
          // Serializer reloaded before the high byte: the frame is lost.
          abort   = 1'b1;
          state_d = LO;
        end else begin
          state_d = HI;
        end
      end
      HI: begin
        push    = 1'b1;
        state_d = ld ? LO : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // FIFO pointer/occupancy update and error bookkeeping.
  always_comb begin
    full    = (level_q == LW'(DEPTH));
    pop     = valid_q && word_ready;
    // A full FIFO still accepts a word when the head leaves in the same cycle.
    wr_en   = push && (!full || pop);
    ovf_evt = push && full && !pop;

    wptr_d  = wptr_q + LW'(wr_en);
    rptr_d  = rptr_q + LW'(pop);
    level_d = level_q;
    if (wr_en && !pop)      level_d = level_q + LW'(1);
    else if (!wr_en && pop) level_d = level_q - LW'(1);
    valid_d = (level_d != '0);

    // Events in the clearing cycle win over clr_err.
    ovf_d     = (ovf_q & ~clr_err) | ovf_evt;
    drop_base = clr_err ? '0 : drop_q;
    drop_d    = drop_base;
    if (abort && (drop_base != '1)) drop_d = drop_base + CNT_W'(1);
  end

  // Control state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (!rst_n) begin
      state_q <= IDLE;
      lo_q    <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
      valid_q <= 1'b0;
      ovf_q   <= 1'b0;
      drop_q  <= '0;
    end else begin
      state_q <= state_d;
      lo_q    <= lo_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      level_q <= level_d;
      valid_q <= valid_d;
      ovf_q   <= ovf_d;
      drop_q  <= drop_d;
    end
  end

  // FIFO storage write.
  always_ff @(posedge clk) begin
    // NOTE: storage is not reset; entries are only visible through valid pointers.
    if (wr_en) mem_q[wptr_q[AW-1:0]] <= push_word;
  end

  // Head word is forced to zero when empty so reset shows word=0.
  assign word       = valid_q ? mem_q[rptr_q[AW-1:0]] : 16'h0000;
  assign word_valid = valid_q;
  assign overflow   = ovf_q;
  assign drop_cnt   = drop_q;
  assign level      = level_q;

endmodule

// File: tb/tb_mac_sipo_rx.sv
// Directed bench for mac_sipo_rx (DEPTH=4, CNT_W=8).
// Inputs change 1 time unit after a rising edge; outputs are sampled there too.
module tb_mac_sipo_rx;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ld;
  logic [7:0]  q;
  logic [15:0] word;
  logic        word_valid;
  logic        word_ready;
  logic        overflow;
  logic        clr_err;
  logic [7:0]  drop_cnt;
  logic [2:0]  level;

  int total = 0;
  int bad   = 0;

  mac_sipo_rx #(.DEPTH(4), .CNT_W(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ld         (ld),
    .q          (q),
    .word       (word),
    .word_valid (word_valid),
    .word_ready (word_ready),
    .overflow   (overflow),
    .clr_err    (clr_err),
    .drop_cnt   (drop_cnt),
    .level      (level)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Edge with ld=1 starting a frame.
  task automatic start();
    ld = 1'b1; q = 8'h00;
    tick();
    ld = 1'b0;
  endtask

  // Low and high bytes on the following two edges; ld_after sets ld on the high-byte edge.
  task automatic bytes(input logic [7:0] lo, input logic [7:0] hi, input logic ld_after);
    q = lo; ld = 1'b0;
    tick();
    q = hi; ld = ld_after;
    tick();
    q = 8'h00; ld = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; ld = 1'b0; q = 8'h00; word_ready = 1'b0; clr_err = 1'b0;
    #3;
    check("rst_valid", word_valid, 0);
    check("rst_level", level, 0);
    check("rst_word", word, 0);
    check("rst_ovf", overflow, 0);
    check("rst_drop", drop_cnt, 0);
    tick(); tick();
    rst_n = 1'b1;

    // Single frame
    start();
    bytes(8'h34, 8'h12, 1'b0);
    check("single_word", word, 16'h1234);
    check("single_valid", word_valid, 1);
    check("single_level", level, 1);
    word_ready = 1'b1;
    tick();
    word_ready = 1'b0;
    check("single_popped", word_valid, 0);

    // Back-to-back frames
    start();
    bytes(8'h01, 8'hA0, 1'b1);
    bytes(8'h02, 8'hB0, 1'b1);
    bytes(8'h03, 8'hC0, 1'b0);
    check("b2b_level", level, 3);
    check("b2b_drop", drop_cnt, 0);
    check("b2b_w0", word, 16'hA001);
    word_ready = 1'b1;
    tick();
    check("b2b_w1", word, 16'hB002);
    tick();
    check("b2b_w2", word, 16'hC003);
    tick();
    word_ready = 1'b0;
    check("b2b_empty", word_valid, 0);

    // Aborted frame
    ld = 1'b1; tick();
    ld = 1'b1; tick();
    bytes(8'h55, 8'h66, 1'b0);
    check("abort_drop", drop_cnt, 1);
    check("abort_level", level, 1);
    check("abort_word", word, 16'h6655);
    word_ready = 1'b1; clr_err = 1'b1;
    tick();
    word_ready = 1'b0; clr_err = 1'b0;
    check("abort_clr_drop", drop_cnt, 0);
    check("abort_popped", word_valid, 0);

    // Overflow with DEPTH=4
    for (int i = 0; i < 4; i++) begin
      start();
      bytes(8'(i), 8'(8'h10 + i), 1'b0);
    end
    check("ovf_full_level", level, 4);
    check("ovf_not_yet", overflow, 0);
    start();
    bytes(8'h04, 8'h14, 1'b0);
    check("ovf_level", level, 4);
    check("ovf_set", overflow, 1);
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    check("ovf_cleared", overflow, 0);
    // Sixth frame completes on the same edge as a pop
    start();
    q = 8'h05; tick();
    q = 8'h15; word_ready = 1'b1; tick();
    q = 8'h00; word_ready = 1'b0;
    check("ovf_pp_level", level, 4);
    check("ovf_pp_flag", overflow, 0);
    check("ovf_head1", word, 16'h1101);
    word_ready = 1'b1;
    tick();
    check("ovf_head2", word, 16'h1202);
    tick();
    check("ovf_head3", word, 16'h1303);
    tick();
    check("ovf_head6", word, 16'h1505);
    tick();
    word_ready = 1'b0;
    check("ovf_drained", word_valid, 0);

    // Reset mid-frame, with a stored word and a nonzero drop count beforehand
    start();
    bytes(8'hAA, 8'hBB, 1'b0);
    ld = 1'b1; tick();
    ld = 1'b1; tick();
    ld = 1'b0; q = 8'h77; tick();
    check("pre_rst_drop", drop_cnt, 1);
    check("pre_rst_level", level, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", word_valid, 0);
    check("mid_rst_level", level, 0);
    check("mid_rst_drop", drop_cnt, 0);
    check("mid_rst_word", word, 0);
    tick();
    q = 8'h00;
    tick();
    rst_n = 1'b1;
    start();
    bytes(8'hC1, 8'hC2, 1'b0);
    check("post_rst_word", word, 16'hC2C1);
    check("post_rst_level", level, 1);
    check("post_rst_drop", drop_cnt, 0);
    word_ready = 1'b1;
    tick();
    word_ready = 1'b0;

    // Saturation: edge 0 enters LO, every later edge with ld=1 aborts
    ld = 1'b1;
    for (int i = 0; i < 255; i++) tick();
    check("sat_254", drop_cnt, 8'hFE);
    for (int i = 0; i < 45; i++) tick();
    ld = 1'b0;
    check("sat_ff", drop_cnt, 8'hFF);
    tick(); tick();
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    check("sat_cleared", drop_cnt, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global timeout so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
